level_classifier: RTL

LEVEL_CLASSIFIER -- requirements
Module: level_classifier

---
 rtl/level_classifier_pkg.sv | 24 ++
 rtl/band_compare.sv | 18 +
 rtl/level_classifier.sv | 138 +++++++++++++
 3 files changed

// File: rtl/level_classifier_pkg.sv
// level_classifier_pkg: class encoding, filter states and default thresholds
package level_classifier_pkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_B1   = 2'd1,
        CLS_B2   = 2'd2,
        CLS_B3   = 2'd3
    } cls_t;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam int THR1_DEF = 3;
    localparam int THR2_DEF = 6;
    localparam int THR3_DEF = 9;

    function automatic logic [2:0] cls_onehot(input cls_t c);
        return {c == CLS_B3, c == CLS_B2, c == CLS_B1};
    endfunction

endpackage

// File: rtl/band_compare.sv
// band_compare: unsigned sample-to-band classification against three inclusive upper bounds
module band_compare
    import level_classifier_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] thr1,
    input  logic [DATA_W-1:0] thr2,
    input  logic [DATA_W-1:0] thr3,
    output cls_t              cls
);

    assign cls = data <= thr1 ? CLS_B1 :
                 data <= thr2 ? CLS_B2 :
                 data <= thr3 ? CLS_B3 : CLS_NONE;

endmodule

// File: rtl/level_classifier.sv
// level_classifier: debounced band classifier with programmable thresholds and entry counters
module level_classifier
    import level_classifier_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int HOLD_CYC = 3,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              thr_ld,
    input  logic [DATA_W-1:0] thr1,
    input  logic [DATA_W-1:0] thr2,
    input  logic [DATA_W-1:0] thr3,
    input  logic              cnt_clr,
    output logic [2:0]        cout,
    output logic              out_none,
    output logic              chg,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    logic [DATA_W-1:0]       thr1_q, thr1_d, thr2_q, thr2_d, thr3_q, thr3_d;
    logic                    thr_ok;
    cls_t                    raw_cls;
    logic                    s1_vld_q, s1_vld_d;
    cls_t                    s1_cls_q, s1_cls_d;
    state_t                  st_q, st_d;
    cls_t                    com_q, com_d, cand_q, cand_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic                    commit;
    logic [2:0]              cout_q, cout_d;
    logic                    none_q, none_d, chg_q, chg_d, cfg_err_q, cfg_err_d;
    logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;

    band_compare #(.DATA_W(DATA_W)) u_cmp (
        .data (in_data),
        .thr1 (thr1_q),
        .thr2 (thr2_q),
        .thr3 (thr3_q),
        .cls  (raw_cls)
    );

    // next-state: threshold load, stage-1 capture, hold filter and counters
    always_comb begin
        thr_ok    = thr1 <= thr2 && thr2 <= thr3;
        thr1_d    = thr_ld && thr_ok ? thr1 : thr1_q;
        thr2_d    = thr_ld && thr_ok ? thr2 : thr2_q;
        thr3_d    = thr_ld && thr_ok ? thr3 : thr3_q;
        cfg_err_d = thr_ld && !thr_ok;
        s1_vld_d  = in_valid;
        s1_cls_d  = in_valid ? raw_cls : s1_cls_q;
        st_d      = st_q;
        cand_d    = cand_q;
        hold_d    = hold_q;
        com_d     = com_q;
        commit    = 1'b0;
        if (s1_vld_q) begin
            if (st_q == ST_STABLE) begin
                if (s1_cls_q != com_q) begin
                    st_d   = ST_PENDING;
                    cand_d = s1_cls_q;
                    hold_d = HW'(1);
                end
            end else if (s1_cls_q == cand_q) begin
                hold_d = hold_q + 1'b1;
            end else if (s1_cls_q == com_q) begin
                st_d   = ST_STABLE;
                hold_d = '0;
            end else begin
                cand_d = s1_cls_q;
                hold_d = HW'(1);
            end
            if (st_d == ST_PENDING && hold_d == HW'(HOLD_CYC)) begin
                commit = 1'b1;
                com_d  = cand_d;
                st_d   = ST_STABLE;
                hold_d = '0;
            end
        end
        cout_d = cls_onehot(com_d);
        none_d = com_d == CLS_NONE;
        chg_d  = commit;
        for (int k = 0; k < 3; k++)
            cnt_d[k] = cnt_clr ? '0 :
                       commit && cout_d[k] && !(&cnt_q[k]) ? cnt_q[k] + 1'b1 : cnt_q[k];
    end

    // state registers with asynchronous reset to defaults
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr1_q    <= DATA_W'(THR1_DEF);
            thr2_q    <= DATA_W'(THR2_DEF);
            thr3_q    <= DATA_W'(THR3_DEF);
            s1_vld_q  <= 1'b0;
            s1_cls_q  <= CLS_NONE;
            st_q      <= ST_STABLE;
            com_q     <= CLS_NONE;
            cand_q    <= CLS_NONE;
            hold_q    <= '0;
            cout_q    <= 3'b000;
            none_q    <= 1'b1;
            chg_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            thr1_q    <= thr1_d;
            thr2_q    <= thr2_d;
            thr3_q    <= thr3_d;
            s1_vld_q  <= s1_vld_d;
            s1_cls_q  <= s1_cls_d;
            st_q      <= st_d;
            com_q     <= com_d;
            cand_q    <= cand_d;
            hold_q    <= hold_d;
            cout_q    <= cout_d;
            none_q    <= none_d;
            chg_q     <= chg_d;
            cfg_err_q <= cfg_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cout     = cout_q;
    assign out_none = none_q;
    assign chg      = chg_q;
    assign cfg_err  = cfg_err_q;
    assign cnt1     = cnt_q[0];
    assign cnt2     = cnt_q[1];
    assign cnt3     = cnt_q[2];

endmodule
